// File: rtl/toggle_sync_pkg.sv
// Shared definitions for the toggle-handshake receiver and its synchronizer.
package toggle_sync_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned COUNT_WIDTH        = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer; also used by the sender to bring the ack back.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk_In,
    input  logic Reset_In,
    input  logic D_In,
    output logic Q_Out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_In};
        end
    end

    assign Q_Out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_sync_receiver.sv
// Receiving end of the toggle handshake: synchronizes the request toggle, captures the
// word, offers it on valid/ready and returns an ack toggle once it has been accepted.
module toggle_sync_receiver
    import toggle_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    input  logic                   Req_Toggle_In,
    input  logic [DATA_WIDTH-1:0]  Data_In,
    input  logic                   Ready_In,
    output logic                   Valid_Out,
    output logic [DATA_WIDTH-1:0]  Data_Out,
    output logic                   Ack_Toggle_Out,
    output logic [COUNT_WIDTH-1:0] Event_Count_Out,
    output logic                   Overrun_Out
);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   req_sync;
    logic                   new_req;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .Clk_In   (Clk_In),
        .Reset_In (Reset_In),
        .D_In     (Req_Toggle_In),
        .Q_Out    (req_sync)
    );

    assign new_req = (req_sync != req_seen_q);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        req_seen_d = req_seen_q;
        ack_d      = ack_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        unique case (state_q)
            ST_IDLE: begin
                if (new_req) begin
                    data_d     = Data_In;
                    req_seen_d = req_sync;
                    state_d    = ST_VALID;
                end
            end
            ST_VALID: begin
                // req_seen is left alone so a second extra toggle cancels the first.
                if (new_req) begin
                    overrun_d = 1'b1;
                end
                if (Ready_In) begin
                    ack_d   = ~ack_q;
                    count_d = count_q + COUNT_WIDTH'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
        end
    end

    assign Valid_Out       = (state_q == ST_VALID);
    assign Data_Out        = data_q;
    assign Ack_Toggle_Out  = ack_q;
    assign Event_Count_Out = count_q;
    assign Overrun_Out     = overrun_q;

endmodule

// File: tb/tb_toggle_sync_receiver.sv
// Randomized bench for toggle_sync_receiver against a transaction-level sender/receiver model.
module tb_toggle_sync_receiver;

    logic       clk;
    logic       rst;
    logic       req;
    logic [7:0] data_in;
    logic       ready;
    logic       valid;
    logic [7:0] data_out;
    logic       ack;
    logic [7:0] count;
    logic       overrun;

    int n_checks;
    int n_fail;

    // Reference model: total accepted words since reset, and the sticky error flag.
    int   accepted;
    logic exp_overrun;

    toggle_sync_receiver #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .Clk_In          (clk),
        .Reset_In        (rst),
        .Req_Toggle_In   (req),
        .Data_In         (data_in),
        .Ready_In        (ready),
        .Valid_Out       (valid),
        .Data_Out        (data_out),
        .Ack_Toggle_Out  (ack),
        .Event_Count_Out (count),
        .Overrun_Out     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_count"}, 32'(count), 32'(accepted % 256));
        check_eq({tag, "_ack"}, 32'(ack), 32'(accepted % 2));
        check_eq({tag, "_ovr"}, 32'(overrun), 32'(exp_overrun));
    endtask

    // One complete handshake: toggle, expect Valid_Out exactly two edges later,
    // hold off acceptance for 'stall' cycles while Data_In moves to 'alt'.
    task automatic send_word(input logic [7:0] d, input int stall, input logic [7:0] alt);
        data_in = d;
        req     = ~req;
        ready   = 1'($urandom % 2);
        tick();
        check_eq("lat_k", 32'(valid), 32'd0);
        check_counters("idle_rdy_k");
        ready = 1'($urandom % 2);
        tick();
        check_eq("lat_k1", 32'(valid), 32'd0);
        check_counters("idle_rdy_k1");
        ready = 1'($urandom % 2);
        tick();
        check_eq("lat_k2_valid", 32'(valid), 32'd1);
        check_eq("capture", 32'(data_out), 32'(d));
        check_counters("captured");
        ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            data_in = alt;
            tick();
            check_eq("hold_valid", 32'(valid), 32'd1);
            check_eq("hold_data", 32'(data_out), 32'(d));
            check_counters("hold");
        end
        ready = 1'b1;
        tick();
        accepted++;
        check_eq("accept_valid", 32'(valid), 32'd0);
        check_eq("accept_data", 32'(data_out), 32'(d));
        check_counters("accept");
        ready = 1'($urandom % 2);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        accepted    = 0;
        exp_overrun = 1'b0;
        rst         = 1'b1;
        req         = 1'b0;
        data_in     = 8'h00;
        ready       = 1'b0;

        #2;
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_counters("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single word with immediate acceptance, then backpressure.
        send_word(8'hA5, 0, 8'hA5);
        send_word(8'hA5, 5, 8'h3C);

        // Fill up to 256 handshakes to exercise the counter wrap.
        for (int w = 0; w < 254; w++) begin
            send_word(8'($urandom), int'($urandom_range(0, 3)), 8'($urandom));
        end
        check_eq("wrap_count", 32'(count), 32'd0);
        check_eq("wrap_ack", 32'(ack), 32'd0);

        // Overrun: two extra toggles while the word is held.
        data_in = 8'h5A;
        req     = ~req;
        ready   = 1'b0;
        tick();
        tick();
        tick();
        check_eq("ovr_valid", 32'(valid), 32'd1);
        check_eq("ovr_pre", 32'(overrun), 32'd0);
        data_in = 8'hC3;
        req     = ~req;
        exp_overrun = 1'b1;
        repeat (3) tick();
        check_eq("ovr_set", 32'(overrun), 32'd1);
        req = ~req;
        repeat (3) tick();
        check_eq("ovr_data", 32'(data_out), 32'h5A);
        check_eq("ovr_hold_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        accepted++;
        check_eq("ovr_accept_valid", 32'(valid), 32'd0);
        check_counters("ovr_accept");
        ready = 1'b0;
        repeat (4) tick();
        check_eq("ovr_no_capture", 32'(valid), 32'd0);
        check_eq("ovr_sticky", 32'(overrun), 32'd1);
        send_word(8'h96, 1, 8'h00);

        // Reset mid-transfer, asserted between clock edges.
        data_in = 8'h77;
        req     = ~req;
        ready   = 1'b0;
        repeat (3) tick();
        check_eq("mid_valid", 32'(valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        accepted    = 0;
        exp_overrun = 1'b0;
        req         = 1'b0;
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_data", 32'(data_out), 32'd0);
        check_counters("mid_rst");
        #2;
        rst = 1'b0;
        repeat (3) tick();
        check_eq("post_rst_valid", 32'(valid), 32'd0);
        check_counters("post_rst");
        send_word(8'hE1, 0, 8'hE1);
        send_word(8'($urandom), 2, 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
